// File: rtl/mult_seq_pkg.sv
// Shared types for the multi-cycle add/sub/mul sequencer.
package mult_seq_pkg;

  // Default operand width; a multiply takes one shift-add iteration per bit.
  localparam int DATA_W    = 16;
  localparam int MUL_ITERS = DATA_W;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mult_seq_ctrl_addsub.sv
// Shared WIDTH-bit ripple add/sub datapath (mode=1 subtracts b from a).
module mult_seq_ctrl_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] bx;
  assign bx = b ^ {WIDTH{mode}};

  // Bit-serial carry ripple; subtract is a + ~b + 1 via carry-in = mode.
  always_comb begin
    logic c;
    logic c_msb_in;
    c        = mode;
    c_msb_in = 1'b0;
    sum      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) c_msb_in = c;
      sum[i] = a[i] ^ bx[i] ^ c;
      c      = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
    end
    cout = c;
    ovf  = c ^ c_msb_in;
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle ADD/SUB/MUL sequencer time-sharing one ripple add/sub datapath.
// MUL is WIDTH shift-add iterations over a {hi,lo} register pair.
// Optional macro ZERO_FLAG_EN adds a registered `zero` output (result == 0).
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = MUL_ITERS,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         opcode,
  input  logic [WIDTH-1:0]   inputA,
  input  logic [WIDTH-1:0]   inputB,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               overflow,
  output logic               err
`ifdef ZERO_FLAG_EN
  ,
  output logic               zero
`endif
);

  state_t             state, state_nxt;
  opcode_t            op_q;
  logic [WIDTH-1:0]   a_q, hi, lo;
  logic [CNT_W-1:0]   cnt;

  logic               is_mul, last, accept;
  logic [WIDTH-1:0]   add_a, add_b, add_s;
  logic               add_mode, add_c, add_v;
  logic [WIDTH-1:0]   mul_hi, mul_lo;
  logic [2*WIDTH-1:0] res_nxt;
  logic               carry_nxt, ovf_nxt, err_nxt;

  assign is_mul = (op_q == OP_MUL);
  assign accept = (state == S_IDLE) && start;
  // ADD/SUB/RSVD finish in one pass; MUL on its final iteration.
  assign last   = !is_mul || (cnt == CNT_W'(WIDTH - 1));

  // Adder steering: MUL accumulates hi + (lo[0] ? A : 0); otherwise A op B (B lives in lo).
  assign add_a    = is_mul ? hi : a_q;
  assign add_b    = is_mul ? (lo[0] ? a_q : '0) : lo;
  assign add_mode = is_mul ? 1'b0 : op_q[0];

  mult_seq_ctrl_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .mode (add_mode),
    .sum  (add_s),
    .cout (add_c),
    .ovf  (add_v)
  );

  assign mul_hi = {add_c, add_s[WIDTH-1:1]};
  assign mul_lo = {add_s[0], lo[WIDTH-1:1]};

  // Values loaded into the output registers on the edge entering DONE.
  always_comb begin
    res_nxt   = '0;
    carry_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        res_nxt   = {{WIDTH{1'b0}}, add_s};
        carry_nxt = add_c;
        ovf_nxt   = add_v;
      end
      OP_MUL: begin
        res_nxt = {mul_hi, mul_lo};
        ovf_nxt = |mul_hi;
      end
      default: err_nxt = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status decode.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_EXEC;
      end
      S_EXEC:  if (last) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, shift-add iteration and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
`ifdef ZERO_FLAG_EN
      zero     <= 1'b0;
`endif
    end else if (accept) begin
      op_q <= opcode_t'(opcode);
      a_q  <= inputA;
      lo   <= inputB;
      hi   <= '0;
      cnt  <= '0;
    end else if (state == S_EXEC) begin
      if (is_mul) begin
        hi  <= mul_hi;
        lo  <= mul_lo;
        cnt <= cnt + 1'b1;
      end
      if (last) begin
        result   <= res_nxt;
        carry    <= carry_nxt;
        overflow <= ovf_nxt;
        err      <= err_nxt;
`ifdef ZERO_FLAG_EN
        zero     <= (res_nxt == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  opcode;
  logic [15:0] inputA, inputB;
  logic        ready, done, carry, overflow, err;
  logic [31:0] result;
`ifdef ZERO_FLAG_EN
  logic        zero;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .opcode   (opcode),
    .inputA   (inputA),
    .inputB   (inputB),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .err      (err)
`ifdef ZERO_FLAG_EN
    ,
    .zero     (zero)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: plain arithmetic on the operands.
  task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] r, output logic c, output logic v, output logic e);
    logic [16:0] s;
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      2'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = {16'h0, s[15:0]};
        c = s[16];
        v = (a[15] == b[15]) && (s[15] != a[15]);
      end
      2'd1: begin
        s = {1'b0, a} - {1'b0, b};
        r = {16'h0, s[15:0]};
        c = (a >= b);
        v = (a[15] != b[15]) && (s[15] != a[15]);
      end
      2'd2: begin
        r = 32'(a) * 32'(b);
        v = (r[31:16] != 16'h0);
      end
      default: e = 1'b1;
    endcase
  endtask

  // Issue one op from IDLE (called #1 after a rising edge), wait for done, check everything.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input string tag, input bit pulse_start);
    logic [31:0] er;
    logic        ec, ev, ee;
    int          lat, ndone;
    model(op, a, b, er, ec, ev, ee);
    chk({tag, ".ready_pre"}, 64'(ready), 64'd1);
    opcode = op; inputA = a; inputB = b; start = 1'b1;
    @(posedge clk); #1;
    if (!pulse_start) start = 1'b0;
    else begin opcode = 2'd0; inputA = ~a; inputB = ~b; end
    chk({tag, ".ready_busy"}, 64'(ready), 64'd0);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 64'(lat), (op == 2'd2) ? 64'd16 : 64'd1);
    chk({tag, ".result"}, 64'(result), 64'(er));
    chk({tag, ".carry"}, 64'(carry), 64'(ec));
    chk({tag, ".overflow"}, 64'(overflow), 64'(ev));
    chk({tag, ".err"}, 64'(err), 64'(ee));
`ifdef ZERO_FLAG_EN
    chk({tag, ".zero"}, 64'(zero), 64'(er == 32'h0));
`endif
    // done is a single-cycle pulse; no further done while idle with start low
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk({tag, ".one_done"}, 64'(ndone), 64'd0);
    chk({tag, ".ready_post"}, 64'(ready), 64'd1);
    chk({tag, ".result_hold"}, 64'(result), 64'(er));
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; opcode = 2'd0; inputA = '0; inputB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ready", 64'(ready), 64'd1);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.result", 64'(result), 64'd0);
    chk("reset.flags", 64'({carry, overflow, err}), 64'd0);
    reset = 1'b0;

    // Directed corner cases
    run_op(2'd0, 16'hFFFF, 16'h0001, "add_wrap", 1'b0);
    run_op(2'd0, 16'h7FFF, 16'h0001, "add_ovf", 1'b0);
    run_op(2'd1, 16'h0005, 16'h0007, "sub_borrow", 1'b0);
    run_op(2'd2, 16'hFFFF, 16'hFFFF, "mul_max", 1'b0);
    run_op(2'd2, 16'h1234, 16'h0010, "mul_shift", 1'b0);
    run_op(2'd2, 16'hABCD, 16'h4321, "mul_start_spam", 1'b1);
    run_op(2'd3, 16'h1111, 16'h2222, "rsvd", 1'b0);
    run_op(2'd2, 16'h1234, 16'h0000, "mul_zero", 1'b0);
    run_op(2'd0, 16'h0001, 16'h0001, "add_small", 1'b0);

    // Reset during MUL iteration 8: partial product dropped, no done
    opcode = 2'd2; inputA = 16'hFFFF; inputB = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid.ready", 64'(ready), 64'd1);
    chk("rst_mid.result", 64'(result), 64'd0);
    chk("rst_mid.done", 64'(done), 64'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("rst_mid.no_done", 64'(ndone), 64'd0);
    run_op(2'd0, 16'd3, 16'd4, "add_after_rst", 1'b0);

    // Reset beats start on the same edge
    start = 1'b1; reset = 1'b1; opcode = 2'd2;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    chk("rst_vs_start.ready", 64'(ready), 64'd1);

    // Random operations
    for (int n = 0; n < 30; n++) begin
      logic [1:0]  rop;
      logic [15:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (n % 7 == 0) ra = 16'hFFFF;
      if (n % 5 == 0) rb = 16'h8000;
      run_op(rop, ra, rb, $sformatf("rand%0d", n), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: timeout, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
